// File: rtl/traffic_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl_pkg
//  Purpose  : Shared types and encodings for the two-road phase sequencer:
//             phase/state encoding, lamp codes, edit-field codes and small
//             helpers for phase ordering and phase duration lookup.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package traffic_phase_ctrl_pkg;

  // Run phases first, then the two edit states.
  typedef enum logic [2:0] {
    ST_A_G   = 3'd0,
    ST_A_Y   = 3'd1,
    ST_B_G   = 3'd2,
    ST_B_Y   = 3'd3,
    ST_SET_G = 3'd4,
    ST_SET_Y = 3'd5
  } phase_t;

  typedef logic [1:0] lamp_t;
  typedef logic [6:0] secs_t;
  typedef logic [1:0] field_t;

  localparam lamp_t LAMP_GREEN  = 2'b00;
  localparam lamp_t LAMP_YELLOW = 2'b01;
  localparam lamp_t LAMP_RED    = 2'b11;
  localparam lamp_t LAMP_OFF    = 2'b10;

  localparam field_t SF_RUN    = 2'b00;
  localparam field_t SF_GREEN  = 2'b01;
  localparam field_t SF_YELLOW = 2'b10;

  // Successor in the run cycle; anything unexpected restarts at A_G.
  function automatic phase_t next_phase(input phase_t ph);
    phase_t nxt;
    case (ph)
      ST_A_G:  nxt = ST_A_Y;
      ST_A_Y:  nxt = ST_B_G;
      ST_B_G:  nxt = ST_B_Y;
      default: nxt = ST_A_G;
    endcase
    return nxt;
  endfunction

  // Duration loaded into the countdown when entering a run phase.
  function automatic secs_t phase_dur(input phase_t ph, input secs_t g, input secs_t y);
    return ((ph == ST_A_Y) || (ph == ST_B_Y)) ? y : g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl_if
//  Purpose  : Operator/display bundle of the phase sequencer.
//  Ports    : en, btn_mode, btn_inc      (operator side -> controller)
//             lightA, lightB             (lamp codes)
//             timeA, timeB               (seconds to next lamp change)
//             set_field                  (which duration is being edited)
//             modport master = operator/display side, slave = controller.
//  Revision : 1.0  initial release
// ============================================================================
interface traffic_phase_ctrl_if;
  import traffic_phase_ctrl_pkg::*;

  logic   en;
  logic   btn_mode;
  logic   btn_inc;
  lamp_t  lightA;
  lamp_t  lightB;
  secs_t  timeA;
  secs_t  timeB;
  field_t set_field;

  modport master (
    output en, btn_mode, btn_inc,
    input  lightA, lightB, timeA, timeB, set_field
  );

  modport slave (
    input  en, btn_mode, btn_inc,
    output lightA, lightB, timeA, timeB, set_field
  );

endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : Divides CLK down to a one-cycle enable pulse every TICK_DIV
//             cycles, replacing a divided clock.
//  Ports    : CLK, RST_N (async, active-low)
//             run  - count enable
//             clr  - synchronous clear to 0 (wins over run)
//             tick - high for the one cycle where the count is TICK_DIV-1
//  Revision : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int c_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(TICK_DIV - 1);

  logic [c_w-1:0] r_presc;

  assign tick = run && (r_presc == c_last);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (run) begin
      r_presc <= tick ? '0 : (r_presc + c_w'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl
//  Purpose  : Two-road intersection phase sequencer. Cycles A green, A
//             yellow, B green, B yellow with a per-phase seconds countdown,
//             and offers an edit mode for the green and yellow durations.
//  Ports    : CLK, RST_N (async, active-low)
//             bus (slave) - en, btn_mode, btn_inc in;
//                           lightA, lightB, timeA, timeB, set_field out
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DEF_GREEN  = 25,
  parameter int DEF_YELLOW = 3,
  parameter int GREEN_MAX  = 90,
  parameter int YELLOW_MAX = 9
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  traffic_phase_ctrl_if.slave  bus
);

  localparam secs_t c_def_green  = secs_t'(DEF_GREEN);
  localparam secs_t c_def_yellow = secs_t'(DEF_YELLOW);
  localparam secs_t c_green_max  = secs_t'(GREEN_MAX);
  localparam secs_t c_yellow_max = secs_t'(YELLOW_MAX);

  phase_t r_state, w_state_nxt;
  secs_t  r_cnt,   w_cnt_nxt;
  secs_t  r_g_dur, w_g_dur_nxt;
  secs_t  r_y_dur, w_y_dur_nxt;

  logic   w_set_state;
  logic   w_tick;
  phase_t w_ph_adv;

  lamp_t  w_light_a, w_light_b;
  secs_t  w_time_a,  w_time_b;
  field_t w_set_field;

  assign w_set_state = (r_state == ST_SET_G) || (r_state == ST_SET_Y);
  assign w_ph_adv    = next_phase(r_state);

  // Clearing on btn_mode as well keeps the prescaler at 0 from the very
  // first edit cycle, and a run restarts with a full second.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .run   (!w_set_state && bus.en),
    .clr   (w_set_state || bus.btn_mode),
    .tick  (w_tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_A_G;
      r_cnt   <= c_def_green;
      r_g_dur <= c_def_green;
      r_y_dur <= c_def_yellow;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_g_dur <= w_g_dur_nxt;
      r_y_dur <= w_y_dur_nxt;
    end
  end

  // Next state: btn_mode always takes priority, so a simultaneous btn_inc
  // or tick is simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_g_dur_nxt = r_g_dur;
    w_y_dur_nxt = r_y_dur;
    case (r_state)
      ST_SET_G: begin
        if (bus.btn_mode) begin
          w_state_nxt = ST_SET_Y;
        end else if (bus.btn_inc) begin
          w_g_dur_nxt = (r_g_dur == c_green_max) ? secs_t'(1) : (r_g_dur + secs_t'(1));
        end
      end
      ST_SET_Y: begin
        if (bus.btn_mode) begin
          w_state_nxt = ST_A_G;
          w_cnt_nxt   = r_g_dur;
        end else if (bus.btn_inc) begin
          w_y_dur_nxt = (r_y_dur == c_yellow_max) ? secs_t'(1) : (r_y_dur + secs_t'(1));
        end
      end
      default: begin
        // Run phases (and any stray code, which next_phase folds to A_G).
        if (bus.btn_mode) begin
          w_state_nxt = ST_SET_G;
        end else if (w_tick) begin
          if (r_cnt == secs_t'(1)) begin
            w_state_nxt = w_ph_adv;
            w_cnt_nxt   = phase_dur(w_ph_adv, r_g_dur, r_y_dur);
          end else begin
            w_cnt_nxt = r_cnt - secs_t'(1);
          end
        end
      end
    endcase
  end

  // Display decode. The red road waits for the rest of the other road's
  // green plus its full yellow, hence cnt + y_dur during the other green.
  always_comb begin
    w_light_a   = LAMP_OFF;
    w_light_b   = LAMP_OFF;
    w_time_a    = '0;
    w_time_b    = '0;
    w_set_field = SF_RUN;
    case (r_state)
      ST_A_G: begin
        w_light_a = LAMP_GREEN;
        w_light_b = LAMP_RED;
        w_time_a  = r_cnt;
        w_time_b  = r_cnt + r_y_dur;
      end
      ST_A_Y: begin
        w_light_a = LAMP_YELLOW;
        w_light_b = LAMP_RED;
        w_time_a  = r_cnt;
        w_time_b  = r_cnt;
      end
      ST_B_G: begin
        w_light_a = LAMP_RED;
        w_light_b = LAMP_GREEN;
        w_time_a  = r_cnt + r_y_dur;
        w_time_b  = r_cnt;
      end
      ST_B_Y: begin
        w_light_a = LAMP_RED;
        w_light_b = LAMP_YELLOW;
        w_time_a  = r_cnt;
        w_time_b  = r_cnt;
      end
      ST_SET_G: begin
        w_time_a    = r_g_dur;
        w_set_field = SF_GREEN;
      end
      ST_SET_Y: begin
        w_time_a    = r_y_dur;
        w_set_field = SF_YELLOW;
      end
      default: begin
        w_set_field = SF_RUN;
      end
    endcase
  end

  assign bus.lightA    = w_light_a;
  assign bus.lightB    = w_light_b;
  assign bus.timeA     = w_time_a;
  assign bus.timeB     = w_time_b;
  assign bus.set_field = w_set_field;

endmodule
`default_nettype wire
